// File: rtl/fifo_reader_pkg.sv
// rtl/fifo_reader_pkg.sv - shared FSM encodings and skid depth for the FIFO burst reader
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buffer.sv
// rtl/stream_skid_buffer.sv - 2-entry in-order register buffer; head entry drives the output stream
module stream_skid_buffer
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_tvalid,
  input  logic [WIDTH-1:0] i_tdata,
  output logic             o_tvalid,
  output logic [WIDTH-1:0] o_tdata,
  input  logic             i_tready,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_Mem0;
  logic [WIDTH-1:0] r_Mem1;
  logic [1:0]       r_Count;
  logic             w_Pop;

  assign w_Pop    = (r_Count != 2'd0) & i_tready;
  assign o_tvalid = (r_Count != 2'd0);
  assign o_tdata  = r_Mem0;
  assign o_count  = r_Count;

  // r_Mem0 is always the oldest word; a pop shifts r_Mem1 forward
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Mem0  <= '0;
      r_Mem1  <= '0;
      r_Count <= 2'd0;
    end else begin
      case ({i_tvalid, w_Pop})
        2'b10: begin
          if (r_Count == 2'd0) begin
            r_Mem0  <= i_tdata;
            r_Count <= 2'd1;
          end else if (r_Count == 2'd1) begin
            r_Mem1  <= i_tdata;
            r_Count <= 2'd2;
          end
        end
        2'b01: begin
          r_Mem0  <= r_Mem1;
          r_Count <= r_Count - 2'd1;
        end
        2'b11: begin
          if (r_Count == 2'd1) begin
            r_Mem0 <= i_tdata;
          end else begin
            r_Mem0 <= r_Mem1;
            r_Mem1 <= i_tdata;
          end
        end
        default: ;
      endcase
      assert (!(i_tvalid && !w_Pop && r_Count == 2'(SKID_DEPTH)))
        else $error("skid buffer push while full");
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a FIFO in fixed bursts onto a valid/ready stream with SOB/EOB markers
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  output logic             o_Fifo_Rd_En,
  input  logic             i_Fifo_Rd_DV,
  input  logic [WIDTH-1:0] i_Fifo_Rd_Data,
  input  logic             i_Fifo_Empty,
  input  logic             i_Fifo_AE_Flag,
  output logic             o_Tx_DV,
  output logic [WIDTH-1:0] o_Tx_Data,
  output logic             o_Tx_SOB,
  output logic             o_Tx_EOB,
  input  logic             i_Tx_Ready,
  output logic             o_Busy
);

  localparam int            CW   = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  state_t           r_State;
  logic [CW-1:0]    r_Issue_Cnt;
  logic [CW-1:0]    r_Cap_Cnt;
  logic             r_Inflight;
  logic             r_Stall;
  logic [WIDTH+1:0] r_Stall_Head;

  logic [1:0]       w_Buf_Count;
  logic             w_Pop;
  logic [2:0]       w_Credit;
  logic             w_Rd_En;
  logic [WIDTH+1:0] w_Push_Data;
  logic [WIDTH+1:0] w_Head;

  // Occupancy after this cycle's pop; reads stop once buffer + in-flight would exceed the skid depth
  assign w_Pop        = o_Tx_DV & i_Tx_Ready;
  assign w_Credit     = {1'b0, w_Buf_Count} + {2'b00, r_Inflight} - {2'b00, w_Pop};
  assign w_Rd_En      = (r_State == S_READ) & ~i_Fifo_Empty & (w_Credit < 3'(SKID_DEPTH));
  assign o_Fifo_Rd_En = w_Rd_En;
  assign o_Busy       = (r_State != S_IDLE);

  assign w_Push_Data = {(r_Cap_Cnt == '0), (r_Cap_Cnt == LAST), i_Fifo_Rd_Data};
  assign o_Tx_Data   = w_Head[WIDTH-1:0];
  assign o_Tx_SOB    = w_Head[WIDTH+1] & o_Tx_DV;
  assign o_Tx_EOB    = w_Head[WIDTH] & o_Tx_DV;

  stream_skid_buffer #(
    .WIDTH(WIDTH + 2)
  ) u_skid (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_tvalid (i_Fifo_Rd_DV),
    .i_tdata  (w_Push_Data),
    .o_tvalid (o_Tx_DV),
    .o_tdata  (w_Head),
    .i_tready (i_Tx_Ready),
    .o_count  (w_Buf_Count)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State     <= S_IDLE;
      r_Issue_Cnt <= '0;
      r_Cap_Cnt   <= '0;
      r_Inflight  <= 1'b0;
    end else begin
      r_Inflight <= w_Rd_En;
      if (w_Rd_En)      r_Issue_Cnt <= r_Issue_Cnt + CW'(1);
      if (i_Fifo_Rd_DV) r_Cap_Cnt   <= r_Cap_Cnt + CW'(1);
      case (r_State)
        S_IDLE: begin
          if (~i_Fifo_AE_Flag & ~i_Fifo_Empty) begin
            r_State     <= S_READ;
            r_Issue_Cnt <= '0;
            r_Cap_Cnt   <= '0;
          end
        end
        S_READ: begin
          if (w_Rd_En && r_Issue_Cnt == LAST) r_State <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_Pop && w_Head[WIDTH]) r_State <= S_IDLE;
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Stall      <= 1'b0;
      r_Stall_Head <= '0;
    end else begin
      r_Stall      <= o_Tx_DV & ~i_Tx_Ready;
      r_Stall_Head <= {o_Tx_SOB, o_Tx_EOB, o_Tx_Data};
      assert (!(i_Fifo_Rd_DV && !r_Inflight))
        else $error("read data valid with no read in flight");
      assert (!(r_Stall && (!o_Tx_DV || {o_Tx_SOB, o_Tx_EOB, o_Tx_Data} != r_Stall_Head)))
        else $error("stream word changed while stalled");
    end
  end

endmodule
